shift_reg_param: RTL and testbench
==================================

Name: shift_reg_param

Overview:
- Parametrised successor to the 8-bit load/shift register: a bidirectional-mode PISO/SIPO serialiser with configurable width, bit order, and a rotate mode.
- Adds a remaining-bit counter, a busy/empty indication and a one-cycle done pulse, so an upstream controller can stream words without counting cycles itself.
- Sits between the parallel data path and the serial link; its serial output drives the link, and its serial input captures the returning data.

Parameters:
WIDTH, 8, register width in bits (legal range 2..64)
LSB_FIRST, 0, 0 = shift out MSB first and enter sin at the LSB; 1 = shift out LSB first and enter sin at the MSB
ROTATE, 0, 1 = the bit shifted out re-enters at the opposite end and sin is ignored; 0 = sin enters

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
carga  input  1  load strobe: capture cargaData on the next rising edge
cargaData  input  WIDTH  parallel load word
shift  input  1  shift enable, one bit per cycle while asserted
sin  input  1  serial input bit (unused when ROTATE=1)
sout  output  1  current serial output bit, combinational from the register
dataOut  output  WIDTH  register contents (SIPO parallel view)
cuenta  output  $clog2(WIDTH+1)  bits remaining to shift out
ocupado  output  1  high while cuenta != 0
vacio  output  1  high while cuenta == 0
done  output  1  one-cycle pulse on the edge where cuenta goes 1 -> 0

Behaviour:
- Reset (reset=0, asynchronous): register=0, cuenta=0, done=0. Therefore sout=0, dataOut=0, ocupado=0, vacio=1. Release is synchronous to the next edge.
- States (implicit in cuenta):
  - IDLE (cuenta==0) -> BUSY on carga.
  - BUSY -> IDLE on the shift that takes cuenta 1 -> 0.
  - BUSY -> BUSY on a new carga, which restarts cuenta.
- carga=1 at an edge: register<=cargaData, cuenta<=WIDTH, done<=0. carga has priority over shift in the same cycle; that shift is dropped.
- shift=1, carga=0, cuenta>0 at an edge:
  - LSB_FIRST=0: register<={register[WIDTH-2:0], in}.
  - LSB_FIRST=1: register<={in, register[WIDTH-1:1]}.
  - in = sout when ROTATE=1, otherwise sin.
  - cuenta<=cuenta-1.
  - done<=1 only if cuenta==1, else 0.
- shift=1 with cuenta==0 (IDLE): ignored. Register, cuenta and sout hold; done=0.
- sout = register[WIDTH-1] when LSB_FIRST=0, register[0] when LSB_FIRST=1. The first bit is valid the cycle after carga, with zero shift latency.
- done is a single-cycle pulse and deasserts on the following edge regardless of inputs.
- shift deasserted mid-word: all state holds and cuenta is preserved; shifting resumes when shift returns.
- Reset asserted mid-word: immediate return to reset values, and any partial word is discarded.
- cuenta never wraps below 0 and never exceeds WIDTH.
- Implementation rules: no latches; all state is in one clocked process with the async reset in its sensitivity list.

Test Plan:
- WIDTH=8, reset low then high -> sout=0, dataOut=0x00, cuenta=0, vacio=1, done=0.
- Load 0xAA (MSB first) -> sout=1, cuenta=8. One shift with sin=0 -> dataOut=0x54, sout=0, cuenta=7.
- Load 0xCC, then 8 shifts with sin=1:
  - sout sequence 1,1,0,0,1,1,0,0.
  - done high exactly on the cycle after the 8th edge.
  - dataOut=0xFF, vacio=1.
  - A 9th shift leaves 0xFF and cuenta=0 unchanged.
- ROTATE=1, load 0xCC, 8 shifts -> dataOut returns to 0xCC, done pulses once, cuenta=0.
- LSB_FIRST=1, load 0x01 -> sout=1. One shift with sin=1 -> dataOut=0x80, sout=0.
- Simultaneous carga+shift with 0x3C -> dataOut=0x3C, cuenta=8 (no shift). After 3 shifts, drop reset -> all outputs at reset values immediately, vacio=1.

Source files
------------

// File: rtl/shift_reg_param.sv
// rtl/shift_reg_param.sv - parametrised PISO/SIPO shift register with bit counter and done pulse
module shift_reg_param #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit ROTATE    = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       carga,
    input  logic [WIDTH-1:0]           cargaData,
    input  logic                       shift,
    input  logic                       sin,
    output logic                       sout,
    output logic [WIDTH-1:0]           dataOut,
    output logic [$clog2(WIDTH+1)-1:0] cuenta,
    output logic                       ocupado,
    output logic                       vacio,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    count_q;
    logic             done_q;
    logic             in_bit;

    // In rotate mode the outgoing bit is fed back to the opposite end.
    assign sout   = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    assign in_bit = ROTATE ? sout : sin;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (carga) begin
                data_q  <= cargaData;
                count_q <= CW'(WIDTH);
            end else if (shift && (count_q != '0)) begin
                if (LSB_FIRST)
                    data_q <= {in_bit, data_q[WIDTH-1:1]};
                else
                    data_q <= {data_q[WIDTH-2:0], in_bit};
                count_q <= count_q - CW'(1);
                done_q  <= (count_q == CW'(1));
            end
        end
    end

    assign dataOut = data_q;
    assign cuenta  = count_q;
    assign ocupado = (count_q != '0);
    assign vacio   = (count_q == '0);
    assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// tb/tb_shift_reg_param.sv - directed bench for shift_reg_param in MSB-first, rotate and LSB-first builds
module tb_shift_reg_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       carga = 1'b0;
    logic [7:0] cargaData = 8'h00;
    logic       shift = 1'b0;
    logic       sin = 1'b0;

    logic       m_sout, m_ocupado, m_vacio, m_done;
    logic [7:0] m_data;
    logic [3:0] m_cuenta;
    logic       r_sout, r_ocupado, r_vacio, r_done;
    logic [7:0] r_data;
    logic [3:0] r_cuenta;
    logic       l_sout, l_ocupado, l_vacio, l_done;
    logic [7:0] l_data;
    logic [3:0] l_cuenta;

    int total = 0;
    int passed = 0;
    int rot_done_cnt = 0;
    logic [7:0] cc_seq = 8'hCC;

    always #5 clk = ~clk;

    shift_reg_param #(.WIDTH(8), .LSB_FIRST(1'b0), .ROTATE(1'b0)) u_msb (
        .clk(clk), .reset(reset), .carga(carga), .cargaData(cargaData),
        .shift(shift), .sin(sin), .sout(m_sout), .dataOut(m_data),
        .cuenta(m_cuenta), .ocupado(m_ocupado), .vacio(m_vacio), .done(m_done)
    );

    shift_reg_param #(.WIDTH(8), .LSB_FIRST(1'b0), .ROTATE(1'b1)) u_rot (
        .clk(clk), .reset(reset), .carga(carga), .cargaData(cargaData),
        .shift(shift), .sin(sin), .sout(r_sout), .dataOut(r_data),
        .cuenta(r_cuenta), .ocupado(r_ocupado), .vacio(r_vacio), .done(r_done)
    );

    shift_reg_param #(.WIDTH(8), .LSB_FIRST(1'b1), .ROTATE(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .carga(carga), .cargaData(cargaData),
        .shift(shift), .sin(sin), .sout(l_sout), .dataOut(l_data),
        .cuenta(l_cuenta), .ocupado(l_ocupado), .vacio(l_vacio), .done(l_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_async_sout", 64'(m_sout), 64'd0);
        chk("rst_async_vacio", 64'(m_vacio), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rst_sout", 64'(m_sout), 64'd0);
        chk("rst_data", 64'(m_data), 64'h00);
        chk("rst_cuenta", 64'(m_cuenta), 64'd0);
        chk("rst_vacio", 64'(m_vacio), 64'd1);
        chk("rst_ocupado", 64'(m_ocupado), 64'd0);
        chk("rst_done", 64'(m_done), 64'd0);

        carga = 1'b1; cargaData = 8'hAA;
        tick();
        carga = 1'b0;
        chk("aa_sout", 64'(m_sout), 64'd1);
        chk("aa_cuenta", 64'(m_cuenta), 64'd8);
        chk("aa_ocupado", 64'(m_ocupado), 64'd1);
        shift = 1'b1; sin = 1'b0;
        tick();
        shift = 1'b0;
        chk("aa_sh_data", 64'(m_data), 64'h54);
        chk("aa_sh_sout", 64'(m_sout), 64'd0);
        chk("aa_sh_cuenta", 64'(m_cuenta), 64'd7);
        tick();
        chk("hold_data", 64'(m_data), 64'h54);
        chk("hold_cuenta", 64'(m_cuenta), 64'd7);

        carga = 1'b1; cargaData = 8'hCC;
        tick();
        carga = 1'b0;
        shift = 1'b1; sin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cc_sout_%0d", i), 64'(m_sout), 64'(cc_seq[7-i]));
            chk($sformatf("cc_done_lo_%0d", i), 64'(m_done), 64'd0);
            tick();
            if (r_done) rot_done_cnt++;
        end
        chk("cc_done", 64'(m_done), 64'd1);
        chk("cc_data", 64'(m_data), 64'hFF);
        chk("cc_vacio", 64'(m_vacio), 64'd1);
        chk("rot_data", 64'(r_data), 64'hCC);
        chk("rot_cuenta", 64'(r_cuenta), 64'd0);
        tick();
        if (r_done) rot_done_cnt++;
        shift = 1'b0;
        chk("ninth_data", 64'(m_data), 64'hFF);
        chk("ninth_cuenta", 64'(m_cuenta), 64'd0);
        chk("ninth_done", 64'(m_done), 64'd0);
        chk("rot_done_once", 64'(rot_done_cnt), 64'd1);
        chk("rot_data_hold", 64'(r_data), 64'hCC);

        carga = 1'b1; cargaData = 8'h01;
        tick();
        carga = 1'b0;
        chk("lsb_sout_load", 64'(l_sout), 64'd1);
        shift = 1'b1; sin = 1'b1;
        tick();
        shift = 1'b0;
        chk("lsb_data", 64'(l_data), 64'h80);
        chk("lsb_sout", 64'(l_sout), 64'd0);

        carga = 1'b1; shift = 1'b1; sin = 1'b1; cargaData = 8'h3C;
        tick();
        carga = 1'b0;
        chk("prio_data", 64'(m_data), 64'h3C);
        chk("prio_cuenta", 64'(m_cuenta), 64'd8);
        sin = 1'b0;
        tick(); tick(); tick();
        shift = 1'b0;
        chk("mid_data", 64'(m_data), 64'hE0);
        chk("mid_cuenta", 64'(m_cuenta), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_data", 64'(m_data), 64'h00);
        chk("mid_rst_cuenta", 64'(m_cuenta), 64'd0);
        chk("mid_rst_sout", 64'(m_sout), 64'd0);
        chk("mid_rst_vacio", 64'(m_vacio), 64'd1);
        chk("mid_rst_ocupado", 64'(m_ocupado), 64'd0);
        chk("mid_rst_done", 64'(m_done), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
